// File: rtl/ddr3_rd_burst_engine_pkg.sv
// Shared definitions for the DDR3 read burst engine.
// Holds the FSM state encoding and the width helper for the in-flight counter.
package ddr3_rd_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      DRAIN = 3'd2,
      DONE  = 3'd3,
      ABORT = 3'd4
   } state_t;

   // Width of a counter that must hold 0..max_outst inclusive.
   function automatic int outst_w(input int max_outst);
      return $clog2(max_outst) + 1;
   endfunction

endpackage

// File: rtl/ddr3_rd_burst_engine_if.sv
// MIG read command / read return / read FIFO signal bundle for the burst engine.
// master = engine side, slave = MIG + FIFO side.
interface ddr3_rd_burst_engine_if #(
   parameter int ADDR_W = 26
);
   logic              rd_app_rdy;
   logic              rd_app_en;
   logic [ADDR_W-1:0] ddr3_rd_addr;
   logic              app_rd_data_valid;
   logic              ddr3_rd_fifo_almost_full;
   logic              ddr3_rd_fifo_wr_en;
   logic              ddr3_rd_fifo_input_tlast;

   modport master (
      input  rd_app_rdy, app_rd_data_valid, ddr3_rd_fifo_almost_full,
      output rd_app_en, ddr3_rd_addr, ddr3_rd_fifo_wr_en, ddr3_rd_fifo_input_tlast
   );

   modport slave (
      output rd_app_rdy, app_rd_data_valid, ddr3_rd_fifo_almost_full,
      input  rd_app_en, ddr3_rd_addr, ddr3_rd_fifo_wr_en, ddr3_rd_fifo_input_tlast
   );
endinterface

// File: rtl/ddr3_sync_rise.sv
// Multi-flop synchroniser for an asynchronous level, plus a one-cycle rise pulse
// generated from the synchronised level.
module ddr3_sync_rise #(
   parameter int STAGES = 3
) (
   input  logic clk,
   input  logic reset_n,
   input  logic async_in,
   output logic level,
   output logic rise
);
   (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;
   logic level_d;

   // Shift the async level through the chain and keep one extra copy for edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q  <= '0;
         level_d <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples the previous stage's old value.
         sync_q  <= {sync_q[STAGES-2:0], async_in};
         level_d <= sync_q[STAGES-1];
      end
   end

   assign level = sync_q[STAGES-1];
   assign rise  = sync_q[STAGES-1] & ~level_d;
endmodule

// File: rtl/ddr3_rd_burst_engine.sv
// DDR3 read burst engine: on a synchronised enable rise, issues burst read commands
// to the MIG with a credit cap on in-flight reads and forwards returned beats to the
// read FIFO, marking the final beat with tlast. Dropping enable aborts and drains.
// Optional feature macro: DDR3_RD_RING_WRAP_EN (address wraps ring_top -> ring_base).
module ddr3_rd_burst_engine
   import ddr3_rd_pkg::*;
#(
   parameter int BURST_AW    = 23,
   parameter int BEAT_SHIFT  = 3,
   parameter int CNT_W       = 24,
   parameter int MAX_OUTST   = 32,
   parameter int SYNC_STAGES = 3
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            acq_enabled,
   input  logic                            enable_reading,
   input  logic [BURST_AW-1:0]             ddr3_rd_start_addr,
   input  logic [CNT_W-1:0]                ddr3_rd_burst_cnt,
   input  logic [BURST_AW-1:0]             ring_top,
   input  logic [BURST_AW-1:0]             ring_base,
   ddr3_rd_burst_engine_if.master          bus,
   output logic                            reading_done,
   output logic                            reading_aborted,
   output logic [outst_w(MAX_OUTST)-1:0]   outstanding
);
   localparam int                  OUTST_W   = outst_w(MAX_OUTST);
   localparam logic [OUTST_W-1:0]  OUTST_MAX = OUTST_W'(MAX_OUTST);
   localparam logic [OUTST_W-1:0]  OUTST_ONE = OUTST_W'(1);
   localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
   localparam logic [BURST_AW-1:0] ADDR_ONE  = BURST_AW'(1);

   state_t              state, state_next;
   logic                en_sync, en_rise;
   logic [BURST_AW-1:0] addr_gen, addr_next;
   logic [CNT_W-1:0]    issue_cnt, ret_cnt;
   logic                rd_en, wr_en, tlast;
   logic                accept, beat, start;

   ddr3_sync_rise #(.STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .reset_n  (reset_n),
      .async_in (enable_reading),
      .level    (en_sync),
      .rise     (en_rise)
   );

   assign start  = (state == IDLE) && en_rise;
   assign accept = rd_en && bus.rd_app_rdy;
   // Beats arriving with nothing in flight are spurious and ignored entirely.
   assign beat   = bus.app_rd_data_valid && (outstanding != '0);

   // Next burst address after an accepted command.
`ifdef DDR3_RD_RING_WRAP_EN
   always_comb begin
      addr_next = (addr_gen == ring_top) ? ring_base : addr_gen + ADDR_ONE;
   end
`else
   logic unused_ring;
   assign unused_ring = ^{ring_top, ring_base};
   always_comb begin
      addr_next = addr_gen + ADDR_ONE;
   end
`endif

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // FSM next-state logic; losing enable in ISSUE/DRAIN takes priority over progress.
   always_comb begin
      // NOTE: default first so every path assigns state_next and no latch is inferred.
      state_next = state;
      unique case (state)
         IDLE:    if (en_rise)              state_next = ISSUE;
         ISSUE:   if (!en_sync)             state_next = ABORT;
                  else if (issue_cnt == '0) state_next = DRAIN;
         DRAIN:   if (!en_sync)             state_next = ABORT;
                  else if (ret_cnt == '0)   state_next = DONE;
         DONE:    if (!en_sync)             state_next = IDLE;
         ABORT:   if (outstanding == '0)    state_next = IDLE;
         default:                           state_next = IDLE;
      endcase
   end

   // FSM outputs: command request, FIFO write/tlast and status flags.
   always_comb begin
      rd_en           = (state == ISSUE) && !acq_enabled && (issue_cnt != '0) &&
                        !bus.ddr3_rd_fifo_almost_full && (outstanding < OUTST_MAX);
      wr_en           = beat && ((state == ISSUE) || (state == DRAIN));
      tlast           = wr_en && (ret_cnt == CNT_ONE);
      reading_done    = (state == DONE);
      reading_aborted = (state == ABORT) && (outstanding == '0);
   end

   // Address generator and issue/return counters, loaded on a fresh start.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_gen  <= '0;
         issue_cnt <= '0;
         ret_cnt   <= '0;
      end else if (start) begin
         addr_gen  <= ddr3_rd_start_addr;
         issue_cnt <= ddr3_rd_burst_cnt;
         ret_cnt   <= ddr3_rd_burst_cnt;
      end else begin
         if (accept) begin
            addr_gen  <= addr_next;
            issue_cnt <= issue_cnt - CNT_ONE;
         end
         if (wr_en) ret_cnt <= ret_cnt - CNT_ONE;
      end
   end

   // In-flight credit counter; a simultaneous accept and beat cancel out.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         outstanding <= '0;
      end else begin
         unique case ({accept, beat})
            2'b10:   outstanding <= outstanding + OUTST_ONE;
            2'b01:   outstanding <= outstanding - OUTST_ONE;
            default: outstanding <= outstanding;
         endcase
      end
   end

   assign bus.rd_app_en                = rd_en;
   assign bus.ddr3_rd_addr             = {addr_gen, {BEAT_SHIFT{1'b0}}};
   assign bus.ddr3_rd_fifo_wr_en       = wr_en;
   assign bus.ddr3_rd_fifo_input_tlast = tlast;
endmodule
